// File: rtl/systolic_skew_feeder_if.sv
// Row-load handshake and skewed-lane stream between a tile source, the skew feeder and the PE array edge.
interface systolic_skew_feeder_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           hold;
    logic           out_valid;
    logic [N*W-1:0] out_data;
    logic           done;

    modport master (
        output in_valid, in_data, hold,
        input  in_ready, out_valid, out_data, done
    );

    modport slave (
        input  in_valid, in_data, hold,
        output in_ready, out_valid, out_data, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Captures an N x N operand tile row by row, then streams it diagonally skewed into the PE array edge.
// Define SKEW_FEEDER_DOUBLE_BUF_EN for a ping-pong pair of tile banks (load while streaming).
module systolic_skew_feeder #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(2 * N);
    localparam logic [SW-1:0] END_STEP = SW'(2 * N - 1);
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
    localparam logic DBL = 1'b1;
`else
    localparam logic DBL = 1'b0;
`endif

    typedef enum logic {ST_LOAD, ST_STREAM} state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_cnt_q, row_cnt_d;
    logic [SW-1:0]  step_q, step_d;
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [1:0]     full_q, full_d;
    logic [N*W-1:0] tile_q [2][N];
    logic [N*W-1:0] tile_d [2][N];
    logic           out_valid_q, out_valid_d;
    logic [N*W-1:0] out_data_q, out_data_d;
    logic           done_q, done_d;
    logic           hs, hs_last;
    logic [N*W-1:0] cur_data;

    assign bus.in_ready  = ~full_q[wr_bank_q];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;

    assign hs      = bus.in_valid & ~full_q[wr_bank_q];
    assign hs_last = hs & (row_cnt_q == RW'(N - 1));

    // Lane i at step k carries A[i][k-i]; every (i, j) pair outside the diagonal band stays zero.
    always_comb begin
        cur_data = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(step_q) == i + j) begin
                    cur_data[i*W +: W] = tile_q[rd_bank_q][i][j*W +: W];
                end
            end
        end
    end

    // step_q holds the index of the next step to present; step 0 only needs row 0,
    // which is always stored before the tile-completing handshake.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        step_d      = step_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        tile_d      = tile_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        done_d      = 1'b0;

        if (hs) begin
            tile_d[wr_bank_q][row_cnt_q] = bus.in_data;
            if (hs_last) begin
                row_cnt_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = wr_bank_q ^ DBL;
            end else begin
                row_cnt_d = row_cnt_q + RW'(1);
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (full_d[rd_bank_q]) begin
                    state_d          = ST_STREAM;
                    step_d           = SW'(1);
                    out_valid_d      = 1'b1;
                    out_data_d[W-1:0] = tile_q[rd_bank_q][0][W-1:0];
                end
            end
            ST_STREAM: begin
                if (bus.hold) begin
                    step_d = step_q;
                end else if (step_q != END_STEP) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_data;
                    step_d      = step_q + SW'(1);
                end else begin
                    done_d            = 1'b1;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = rd_bank_q ^ DBL;
                    if (full_d[rd_bank_d]) begin
                        step_d           = SW'(1);
                        out_valid_d      = 1'b1;
                        out_data_d[W-1:0] = tile_q[rd_bank_d][0][W-1:0];
                    end else begin
                        state_d = ST_LOAD;
                        step_d  = '0;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            row_cnt_q   <= '0;
            step_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    tile_q[b][r] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            step_q      <= step_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            tile_q      <= tile_d;
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4, W=8): vector table, hand-written corner
// sequences and randomized tiles checked against a diagonal-skew reference model.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int STEPS = 2 * N - 1;
`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
    localparam logic DBL = 1'b1;
`else
    localparam logic DBL = 1'b0;
`endif

    typedef logic [N-1:0][N-1:0][W-1:0] tile_t;  // [row][col]
    typedef struct {
        logic           valid;
        logic [N*W-1:0] data;
        logic           done;
        logic           ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    systolic_skew_feeder_if #(.N(N), .W(W)) bus ();
    systolic_skew_feeder #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t e);
        chk1({tag, ".valid"}, bus.out_valid, e.valid);
        chkd({tag, ".data"},  bus.out_data,  e.data);
        chk1({tag, ".done"},  bus.done,      e.done);
        chk1({tag, ".ready"}, bus.in_ready,  e.ready);
    endtask

    // Reference: lane i at step k is A[i][k-i] when that column exists, else zero.
    function automatic logic [N*W-1:0] ref_step(input tile_t t, input int k);
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (k - i >= 0 && k - i < N) v[i*W +: W] = t[i][k-i];
        end
        return v;
    endfunction

    // gap_mode: 0 back-to-back, 1 alternate valid/idle, 2 random idle cycles
    task automatic load_tile(input tile_t t, input int gap_mode, input string tag);
        for (int r = 0; r < N; r++) begin
            int gaps;
            gaps = (gap_mode == 2) ? int'($urandom_range(2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = (N*W)'($urandom);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = t[r];
            chk1({tag, ".load_ready"}, bus.in_ready, 1'b1);
            chk1({tag, ".load_idle"},  bus.out_valid, 1'b0);
            tick();
            bus.in_valid = 1'b0;
            if (gap_mode == 1 && r != N - 1) begin
                bus.in_data = (N*W)'($urandom);
                tick();
            end
        end
    endtask

    // Entered one cycle after the tile-completing handshake; returns in the done cycle.
    task automatic run_stream(input tile_t t, input int hold_pct, input logic offer, input string tag);
        int   k;
        logic bubble;
        logic fin;
        k = 0; bubble = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 8 * N + 64 && !fin; cyc++) begin
            if (bubble) begin
                chk1({tag, ".bub_valid"}, bus.out_valid, 1'b0);
                chkd({tag, ".bub_data"},  bus.out_data,  '0);
                chk1({tag, ".bub_done"},  bus.done,      1'b0);
                chk1({tag, ".bub_ready"}, bus.in_ready,  DBL);
            end else if (k < STEPS) begin
                chk1({tag, ".valid"}, bus.out_valid, 1'b1);
                chkd({tag, ".data"},  bus.out_data,  ref_step(t, k));
                chk1({tag, ".done"},  bus.done,      1'b0);
                chk1({tag, ".ready"}, bus.in_ready,  DBL);
                k++;
            end else begin
                chk1({tag, ".end_valid"}, bus.out_valid, 1'b0);
                chkd({tag, ".end_data"},  bus.out_data,  '0);
                chk1({tag, ".end_done"},  bus.done,      1'b1);
                chk1({tag, ".end_ready"}, bus.in_ready,  1'b1);
                fin = 1'b1;
            end
            if (!fin) begin
                bus.hold     = (hold_pct > 0 && int'($urandom_range(99)) < hold_pct) ? 1'b1 : 1'b0;
                bubble       = bus.hold;
                bus.in_valid = (offer && $urandom_range(1) == 1) ? 1'b1 : 1'b0;
                bus.in_data  = (N*W)'($urandom);
                tick();
            end
        end
        bus.hold     = 1'b0;
        bus.in_valid = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: done got 0, want 1 within cycle budget", tag);
        end
    endtask

    initial begin
        tile_t base, fresh, ff, rnd, t1, t2;
        vec_t  basic_tbl [STEPS + 1];
        int    cnt [N];
        int    first [N];

        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                base[r][j] = W'(16 * r + j);
                ff[r][j]   = 8'hFF;
                t1[r][j]   = 8'h11;
                t2[r][j]   = 8'h22;
            end
        end
        basic_tbl[0] = '{1'b1, 32'h00000000, 1'b0, DBL};
        basic_tbl[1] = '{1'b1, 32'h00001001, 1'b0, DBL};
        basic_tbl[2] = '{1'b1, 32'h00201102, 1'b0, DBL};
        basic_tbl[3] = '{1'b1, 32'h30211203, 1'b0, DBL};
        basic_tbl[4] = '{1'b1, 32'h31221300, 1'b0, DBL};
        basic_tbl[5] = '{1'b1, 32'h32230000, 1'b0, DBL};
        basic_tbl[6] = '{1'b1, 32'h33000000, 1'b0, DBL};
        basic_tbl[7] = '{1'b0, 32'h00000000, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.hold     = 1'b0;
        rst          = 1'b1;
        #1;
        chk1("reset.valid", bus.out_valid, 1'b0);
        chkd("reset.data",  bus.out_data,  '0);
        chk1("reset.done",  bus.done,      1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk1("reset.ready_after", bus.in_ready, 1'b1);

        // Basic tile, back-to-back rows
        load_tile(base, 0, "basic");
        for (int c = 0; c <= STEPS; c++) begin
            chk_vec($sformatf("basic.c%0d", c), basic_tbl[c]);
            tick();
        end
        chk1("basic.done_once", bus.done, 1'b0);
        chk1("basic.ready_idle", bus.in_ready, 1'b1);

        // Alternating valid on load; single bank refuses beats offered while streaming
        load_tile(base, 1, "gaps");
        for (int c = 0; c <= STEPS; c++) begin
            chk_vec($sformatf("gaps.c%0d", c), basic_tbl[c]);
            if (c == STEPS) break;
            bus.in_valid = ~DBL;
            bus.in_data  = (N*W)'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;

        // One hold bubble after step 2
        load_tile(base, 0, "hold");
        for (int c = 0; c < 3; c++) begin
            chk_vec($sformatf("hold.c%0d", c), basic_tbl[c]);
            bus.hold = (c == 2) ? 1'b1 : 1'b0;
            tick();
        end
        bus.hold = 1'b0;
        chk_vec("hold.bubble", '{1'b0, '0, 1'b0, DBL});
        tick();
        for (int c = 3; c <= STEPS; c++) begin
            chk_vec($sformatf("hold.c%0d", c), basic_tbl[c]);
            if (c != STEPS) tick();
        end

        // Asynchronous reset while step 4 is on the lanes
        tick();
        load_tile(base, 0, "arst");
        for (int c = 0; c <= 4; c++) begin
            chk_vec($sformatf("arst.c%0d", c), basic_tbl[c]);
            if (c < 4) tick();
        end
        #3 rst = 1'b1;
        #1;
        chk1("arst.valid_now", bus.out_valid, 1'b0);
        chkd("arst.data_now",  bus.out_data,  '0);
        chk1("arst.done_now",  bus.done,      1'b0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < STEPS + 2; c++) begin
            tick();
            chk1("arst.no_done",  bus.done,      1'b0);
            chk1("arst.no_valid", bus.out_valid, 1'b0);
            chk1("arst.ready",    bus.in_ready,  1'b1);
        end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                fresh[r][j] = W'($urandom_range(1, 255));
        load_tile(fresh, 0, "arst.fresh");
        run_stream(fresh, 0, 1'b0, "arst.fresh");
        tick();

        // All-0xFF tile: each lane lit for exactly N consecutive steps starting at step i
        for (int i = 0; i < N; i++) begin
            cnt[i]   = 0;
            first[i] = -1;
        end
        load_tile(ff, 0, "ff");
        for (int k = 0; k < STEPS; k++) begin
            chk1("ff.valid", bus.out_valid, 1'b1);
            for (int i = 0; i < N; i++) begin
                if (bus.out_data[i*W +: W] != '0) begin
                    if (first[i] < 0) first[i] = k;
                    if (first[i] >= 0 && k - first[i] == cnt[i]) cnt[i]++;
                end
            end
            tick();
        end
        chk1("ff.done", bus.done, 1'b1);
        for (int i = 0; i < N; i++) begin
            chkd($sformatf("ff.lane%0d_count", i), (N*W)'(cnt[i]),   (N*W)'(N));
            chkd($sformatf("ff.lane%0d_first", i), (N*W)'(first[i]), (N*W)'(i));
        end
        tick();

        // Randomized tiles, load gaps, hold bubbles and refused beats
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++)
                for (int j = 0; j < N; j++)
                    rnd[r][j] = W'($urandom);
            load_tile(rnd, 2, $sformatf("rand%0d", t));
            run_stream(rnd, 30, ~DBL, $sformatf("rand%0d", t));
            tick();
        end

`ifdef SKEW_FEEDER_DOUBLE_BUF_EN
        // Ping-pong: second tile loaded during the first stream, streamed with no gap
        load_tile(t1, 0, "dbl.t1");
        for (int c = 0; c <= 2 * STEPS; c++) begin
            logic           ev;
            logic           ed;
            logic [N*W-1:0] exd;
            ev  = (c < 2 * STEPS);
            ed  = (c == STEPS) || (c == 2 * STEPS);
            exd = (c < STEPS) ? ref_step(t1, c) : (c < 2 * STEPS) ? ref_step(t2, c - STEPS) : '0;
            chk1($sformatf("dbl.c%0d.valid", c), bus.out_valid, ev);
            chkd($sformatf("dbl.c%0d.data", c),  bus.out_data,  exd);
            chk1($sformatf("dbl.c%0d.done", c),  bus.done,      ed);
            chk1($sformatf("dbl.c%0d.ready", c), bus.in_ready,  !(c >= N && c < STEPS));
            if (c < N) begin
                bus.in_valid = 1'b1;
                bus.in_data  = t2[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (c < 2 * STEPS) tick();
        end
        bus.in_valid = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
